// File: rtl/sipo_ctrl_pkg.sv
// Shared state encoding and width helper for the SIPO frame sequencer.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } sipo_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register (LSB-first arrival) plus the parallel holding register.
module sipo_shift_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_data
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] p_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q  <= '0;
      p_data_q <= '0;
    end else begin
      // Bits enter at the top so the first bit of a frame ends at bit 0.
      if (shift_en) shreg_q <= {s_in, shreg_q[WIDTH-1:1]};
      if (load_en)  p_data_q <= shreg_q;
    end
  end

  assign p_data = p_data_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer: counts WIDTH qualified bits, then hands the word to a
// valid/ready holding register with a sticky overrun flag.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             p_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sipo_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             p_valid_q;
  logic             overrun_q;
  logic             shift_en;
  logic             load_en;

  // A restart strobe in SHIFT discards the current bit along with the partial word.
  assign shift_en = (state_q == ST_SHIFT) && s_valid && !frame_start;
  assign load_en  = (state_q == ST_LATCH) && (!p_valid_q || p_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (frame_start) begin
            cnt_q <= '0;
          end else if (s_valid) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_LATCH;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LATCH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      if (load_en)                     p_valid_q <= 1'b1;
      else if (p_valid_q && p_ready)   p_valid_q <= 1'b0;

      // Set has priority over the synchronous clear.
      if ((state_q == ST_LATCH) && p_valid_q && !p_ready) overrun_q <= 1'b1;
      else if (clr_ovr)                                   overrun_q <= 1'b0;
    end
  end

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .load_en  (load_en),
    .s_in     (s_in),
    .p_data   (p_data)
  );

  assign p_valid = p_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
